// File: rtl/fetch_defs.sv
// -----------------------------------------------------------------------------
// fetch_defs: shared definitions for the fetch controller.
//   pcsrc_e : next-PC mux select encodings (PC_SEQ, PC_BR, PC_JMP)
//   state_e : fetch controller FSM states
//   pend_e  : deferred-redirect encodings held while decode is stalled
//   merge_pend() : folds a new redirect request into a pending one
// -----------------------------------------------------------------------------
package fetch_defs;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JMP = 2'b10
    } pcsrc_e;

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_BUBBLE = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        PEND_NONE = 2'b00,
        PEND_BR   = 2'b01,
        PEND_JMP  = 2'b10
    } pend_e;

    // A jump always wins over a branch; a branch only fills an empty slot.
    function automatic pend_e merge_pend(pend_e cur, logic jump, logic br_taken);
        pend_e res;
        res = cur;
        if (jump)
            res = PEND_JMP;
        else if (br_taken && (cur == PEND_NONE))
            res = PEND_BR;
        return res;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if: control bundle between decode/datapath and the fetch controller.
//   Stall, Br_taken, Jump, Halt, Resume : requests from decode/execute
//   PCsrc, PC_En                         : drive the fetch datapath directly
//   Inst_valid, Flush                    : qualify/squash the fetched instruction
//   Fetch_cnt, Redir_cnt                 : performance counters
// master = fetch controller side, slave = pipeline side.
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             Stall;
    logic             Br_taken;
    logic             Jump;
    logic             Halt;
    logic             Resume;
    logic [1:0]       PCsrc;
    logic             PC_En;
    logic             Inst_valid;
    logic             Flush;
    logic [CNT_W-1:0] Fetch_cnt;
    logic [CNT_W-1:0] Redir_cnt;

    modport master (
        input  Stall, Br_taken, Jump, Halt, Resume,
        output PCsrc, PC_En, Inst_valid, Flush, Fetch_cnt, Redir_cnt
    );

    modport slave (
        output Stall, Br_taken, Jump, Halt, Resume,
        input  PCsrc, PC_En, Inst_valid, Flush, Fetch_cnt, Redir_cnt
    );
endinterface

// File: rtl/fetch_ctrl_perf_cnt.sv
// -----------------------------------------------------------------------------
// perf_cnt: free-running wrapping event counter.
//   clk   : clock, rising edge
//   clr   : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current value, wraps from all-ones to zero
// -----------------------------------------------------------------------------
module perf_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl: instruction-fetch sequencing controller.
//   Clk : clock, rising edge
//   Clr : synchronous active-high reset; also forces all control outputs low
//   bus : fetch_ctrl_if.master -- pipeline requests in, PC control and
//         performance counters out
// Redirects seen while decode is stalled are parked in 'pend' and applied on
// the first unstalled RUN cycle; every applied redirect is followed by one
// BUBBLE cycle while the squashed slot drains.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         Clk,
    input  logic         Clr,
    fetch_ctrl_if.master bus
);
    state_e state, state_nxt;
    pend_e  pend, pend_nxt;
    pend_e  redir;
    pcsrc_e pc_src;
    logic   pc_en;
    logic   inst_valid;
    logic   flush;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state <= ST_INIT;
            pend  <= PEND_NONE;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        pend_nxt   = pend;
        pc_src     = PC_SEQ;
        pc_en      = 1'b0;
        inst_valid = 1'b0;
        flush      = 1'b0;
        // Current request combined with anything parked during a stall.
        redir      = merge_pend(pend, bus.Jump, bus.Br_taken);

        unique case (state)
            ST_INIT: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                inst_valid = 1'b1;
                if (bus.Halt) begin
                    state_nxt = ST_HALTED;
                end else if (bus.Stall) begin
                    pend_nxt = redir;
                end else begin
                    pc_en    = 1'b1;
                    pend_nxt = PEND_NONE;
                    if (redir == PEND_JMP) begin
                        pc_src    = PC_JMP;
                        flush     = 1'b1;
                        state_nxt = ST_BUBBLE;
                    end else if (redir == PEND_BR) begin
                        pc_src    = PC_BR;
                        flush     = 1'b1;
                        state_nxt = ST_BUBBLE;
                    end
                end
            end
            ST_BUBBLE: begin
                pc_en     = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_HALTED: begin
                if (bus.Resume)
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_INIT;
        endcase

        // Reset is visible on the outputs in the same cycle it is asserted.
        if (Clr) begin
            pc_src     = PC_SEQ;
            pc_en      = 1'b0;
            inst_valid = 1'b0;
            flush      = 1'b0;
        end
    end

    assign bus.PCsrc      = pc_src;
    assign bus.PC_En      = pc_en;
    assign bus.Inst_valid = inst_valid;
    assign bus.Flush      = flush;

    perf_cnt #(.W(CNT_W)) u_fetch_cnt (
        .clk   (Clk),
        .clr   (Clr),
        .inc   (inst_valid & ~bus.Stall & ~flush),
        .count (bus.Fetch_cnt)
    );

    perf_cnt #(.W(CNT_W)) u_redir_cnt (
        .clk   (Clk),
        .clr   (Clr),
        .inc   (flush),
        .count (bus.Redir_cnt)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl: self-checking bench for fetch_ctrl with a 4-bit counter width
// so counter wrap is reached quickly. A behavioural model tracks the expected
// controller phase, parked redirect and event counts; every cycle the DUT
// outputs are compared against it. Directed scenarios run first, followed by
// randomized traffic.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
    localparam int W    = 4;
    localparam int MODV = 1 << W;

    // Model phases (independent of the RTL encoding).
    localparam int P_START  = 0;
    localparam int P_FETCH  = 1;
    localparam int P_DRAIN  = 2;
    localparam int P_PARKED = 3;

    logic Clk = 1'b0;
    logic Clr;
    always #5 Clk = ~Clk;

    fetch_ctrl_if #(.CNT_W(W)) bus ();

    fetch_ctrl #(.CNT_W(W)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    int m_phase = P_START;
    int m_pend  = 0;       // 0 none, 1 branch, 2 jump
    int m_fetch = 0;
    int m_redir = 0;
    bit m_known = 1'b0;    // counters are defined only after the first clear

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check the combinational outputs mid-cycle,
    // then advance the model across the rising edge.
    task automatic apply(input bit clr, input bit stall, input bit br,
                         input bit jmp, input bit halt, input bit resume);
        int e_src, e_en, e_iv, e_fl, req, eff;
        Clr          = clr;
        bus.Stall    = stall;
        bus.Br_taken = br;
        bus.Jump     = jmp;
        bus.Halt     = halt;
        bus.Resume   = resume;

        req   = jmp ? 2 : (br ? 1 : 0);
        eff   = (req > m_pend) ? req : m_pend;
        e_src = 0; e_en = 0; e_iv = 0; e_fl = 0;
        if (!clr) begin
            case (m_phase)
                P_DRAIN: e_en = 1;
                P_FETCH: begin
                    e_iv = 1;
                    if (!halt && !stall) begin
                        e_en = 1;
                        e_src = eff;      // 0 seq, 1 branch, 2 jump
                        e_fl = (eff != 0) ? 1 : 0;
                    end
                end
                default: ;
            endcase
        end

        #3;
        check("PCsrc", 32'(bus.PCsrc), 32'(e_src));
        check("PC_En", 32'(bus.PC_En), 32'(e_en));
        check("Inst_valid", 32'(bus.Inst_valid), 32'(e_iv));
        check("Flush", 32'(bus.Flush), 32'(e_fl));
        if (m_known) begin
            check("Fetch_cnt", 32'(bus.Fetch_cnt), 32'(m_fetch));
            check("Redir_cnt", 32'(bus.Redir_cnt), 32'(m_redir));
        end

        @(posedge Clk);
        if (clr) begin
            m_phase = P_START;
            m_pend  = 0;
            m_fetch = 0;
            m_redir = 0;
            m_known = 1'b1;
        end else begin
            if (e_iv == 1 && !stall && e_fl == 0) m_fetch = (m_fetch + 1) % MODV;
            if (e_fl == 1) m_redir = (m_redir + 1) % MODV;
            case (m_phase)
                P_START, P_DRAIN: m_phase = P_FETCH;
                P_PARKED: if (resume) m_phase = P_FETCH;
                default: begin
                    if (halt)        m_phase = P_PARKED;
                    else if (stall)  m_pend  = eff;
                    else begin
                        m_pend = 0;
                        if (e_fl == 1) m_phase = P_DRAIN;
                    end
                end
            endcase
        end
        #1;
    endtask

    // Inputs: clr, stall, br, jmp, halt, resume
    initial begin
        Clr = 1'b1;
        bus.Stall = 0; bus.Br_taken = 0; bus.Jump = 0; bus.Halt = 0; bus.Resume = 0;
        @(posedge Clk); #1;

        // Reset held two cycles, then one INIT cycle, then fetching.
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        // Sequential run of 5 cycles.
        repeat (5) apply(0, 0, 0, 0, 0, 0);
        // Taken branch, bubble, back to run.
        apply(0, 0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        // Redirects under stall: branch then jump, jump wins on release.
        apply(0, 1, 1, 0, 0, 0);
        apply(0, 1, 0, 1, 0, 0);
        apply(0, 1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        // Jump and branch together count as one jump redirect.
        apply(0, 0, 1, 1, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        // Halt, ignored traffic while halted, resume.
        apply(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) apply(0, i % 2, 1, i % 2, 0, 0);
        apply(0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 0);
        // Enough straight fetches to wrap the 4-bit fetch counter.
        repeat (20) apply(0, 0, 0, 0, 0, 0);
        // Clear in the middle of a bubble, then check a clean restart.
        apply(0, 0, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        // Clear while a redirect is parked under stall.
        apply(0, 1, 0, 1, 0, 0);
        apply(1, 1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        // Clear while halted.
        apply(0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            apply(($urandom % 60) == 0,
                  ($urandom % 3) == 0,
                  ($urandom % 5) == 0,
                  ($urandom % 7) == 0,
                  ($urandom % 25) == 0,
                  ($urandom % 4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
